se_sram_mrw_2_lanes: RTL and testbench
======================================

Name: se_sram_mrw_2_lanes

Overview:
- Parametrised single-clock true dual-port SRAM; successor to the fixed-size se_sram_mrw_2_* wrappers.
- Adds per-lane write masks, defined same-address collision/forwarding rules, an optional output pipeline register and per-port read-valid strobes.
- Used wherever a block needs two independent read/write ports onto one array (frame buffers, descriptor tables).

Parameters:
- address_width, 14, address bits per port; depth = 2**address_width.
- data_width, 48, word width in bits; must be an integer multiple of lane_width.
- lane_width, 8, bits per write-mask lane; lanes = data_width/lane_width.
- output_reg, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
- initfile, "", memory init file; empty = no init (array contents X).

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- clk__enable  input  1  clock enable; when low, no state (array, pipeline, valids) changes.
- select_0 / select_1  input  1  port access request.
- read_not_write_0 / read_not_write_1  input  1  1 = read, 0 = write.
- address_0 / address_1  input  address_width  word address.
- write_data_0 / write_data_1  input  data_width  write data.
- write_lane_enable_0 / write_lane_enable_1  input  lanes  per-lane write mask (bit i covers bits [i*lane_width +: lane_width]).
- data_out_0 / data_out_1  output  data_width  read data.
- data_valid_0 / data_valid_1  output  1  high for one cycle when data_out carries a fresh read result.
- init_busy  output  1  high while the init clear runs (constant 0 without the optional feature).

Behaviour:
- Reset (async, reset_n low): data_out_N = 0, data_valid_N = 0, pipeline registers = 0, init_busy per the optional feature. Array contents are not reset.
- Access qualification: an access on port N occurs only on a clk edge with clk__enable=1, select_N=1 and init_busy=0.
- Write: only lanes with write_lane_enable_N[i]=1 are updated; a mask of all zeros is a no-op. A write leaves data_out_N unchanged and does not pulse data_valid_N.
- Read, output_reg=0: data_out_N and data_valid_N update on the same edge that samples the read; the result is visible the cycle after the request.
- Read, output_reg=1: the result goes through one extra register stage and is visible two cycles after the request; back-to-back reads give one result per cycle.
- data_out_N holds its last value until the next read result arrives. data_valid_N drops after one cycle unless another result follows.
- Same-address write/write: per lane, port 0 wins wherever both masks are set; lanes enabled on only one port take that port's data.
- Same-address read on port A with write on port B: port A returns the new data (write-through forwarding) on lanes written by B and old array data on all other lanes.
- Both ports reading the same address: both return identical data.
- clk__enable low: pipeline stages freeze; a pending data_valid stays asserted until the next enabled edge.
- reset_n asserted mid-operation: in-flight reads are discarded (valids go to 0); no partial write occurs on the reset edge.

Optional Feature:
- Macro: SE_SRAM_MRW_2_LANES_INIT_CLEAR_EN.
- Defined: a two-state FSM, CLEAR and IDLE. Reset enters CLEAR with init_busy=1 and counter=0. Each enabled cycle writes zero to address counter; the counter increments. The FSM moves to IDLE after address 2**address_width-1 is written, then init_busy=0. Port requests during CLEAR are ignored (no data_valid). Reset during CLEAR restarts from address 0. Clear takes 2**address_width enabled cycles.
- Not defined: init_busy is tied to 0, there is no FSM, and the array starts from initfile or X.

Test Plan:
- address_width=4, output_reg=0: port 0 writes 0x0000_1234_5678 to address 3 with mask 0x3F; port 1 reads address 3 next cycle -> data_out_1=0x000012345678 and data_valid_1=1 one cycle later.
- Mask test: after the above, port 0 writes 0xFFFFFFFFFFFF to address 3 with mask 0x05; read -> 0x000012FF56FF.
- Collision: both ports write address 7 with masks 0x3F/0x3F, data 0xAAAA…/0x5555… -> read returns 0xAAAAAAAAAAAA. Repeat with masks 0x0F/0x30 -> 0x5555AAAAAAAA.
- Forwarding: port 0 writes 0x111111111111 to address 2 (mask 0x03) while port 1 reads address 2, which holds 0x222222222222 -> data_out_1=0x222222221111.
- output_reg=1: reads of addresses 0,1,2 on consecutive cycles -> data_valid_0 high in cycles 2,3,4, carrying the three words in order. Toggle clk__enable low for one cycle -> outputs hold, then resume.
- SE_SRAM_MRW_2_LANES_INIT_CLEAR_EN, address_width=4: release reset -> init_busy high for 16 cycles, and a read issued in cycle 5 gives no data_valid. After busy drops, a read of any address -> 0. Pulse reset_n low at cycle 8 -> the clear restarts for 16 more cycles.

Source files
------------

// File: rtl/se_sram_mrw_2_lanes.sv
// Single-clock true dual-port SRAM: per-lane write masks, port-0-wins collisions, write-through forwarding, optional output register.
// Optional zero-fill of the array after reset when SE_SRAM_MRW_2_LANES_INIT_CLEAR_EN is defined.
module se_sram_mrw_2_lanes #(
    parameter int address_width = 14,
    parameter int data_width    = 48,
    parameter int lane_width    = 8,
    parameter bit output_reg    = 1'b0,
    parameter     initfile      = ""
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               clk__enable,
    input  logic                               select_0,
    input  logic                               select_1,
    input  logic                               read_not_write_0,
    input  logic                               read_not_write_1,
    input  logic [address_width-1:0]           address_0,
    input  logic [address_width-1:0]           address_1,
    input  logic [data_width-1:0]              write_data_0,
    input  logic [data_width-1:0]              write_data_1,
    input  logic [data_width/lane_width-1:0]   write_lane_enable_0,
    input  logic [data_width/lane_width-1:0]   write_lane_enable_1,
    output logic [data_width-1:0]              data_out_0,
    output logic [data_width-1:0]              data_out_1,
    output logic                               data_valid_0,
    output logic                               data_valid_1,
    output logic                               init_busy
);
    localparam int lanes = data_width / lane_width;
    localparam int depth = 2 ** address_width;

    if (data_width % lane_width != 0) begin : g_bad_lane_width
        $error("data_width must be a multiple of lane_width");
    end

    function automatic logic [data_width-1:0] lane_bits(input logic [lanes-1:0] en);
        lane_bits = '0;
        for (int i = 0; i < lanes; i++)
            lane_bits[i*lane_width +: lane_width] = {lane_width{en[i]}};
    endfunction

    function automatic logic [data_width-1:0] merge(input logic [data_width-1:0] old_w,
                                                    input logic [data_width-1:0] new_w,
                                                    input logic [data_width-1:0] bm);
        return (old_w & ~bm) | (new_w & bm);
    endfunction

    logic [data_width-1:0] mem [depth];
    logic                  busy;
    logic                  go, rd_0, rd_1, wr_0, wr_1, same;
    logic [data_width-1:0] bm_0, bm_1, wword_0, wword_1, rword_0, rword_1;

    // reset_n gates accesses so nothing is written on an edge while reset is held
    assign go   = clk__enable & reset_n & ~busy;
    assign rd_0 = go & select_0 & read_not_write_0;
    assign rd_1 = go & select_1 & read_not_write_1;
    assign wr_0 = go & select_0 & ~read_not_write_0;
    assign wr_1 = go & select_1 & ~read_not_write_1;
    assign same = (address_0 == address_1);
    assign bm_0 = wr_0 ? lane_bits(write_lane_enable_0) : '0;
    assign bm_1 = wr_1 ? lane_bits(write_lane_enable_1) : '0;

    // Port 0's word is built on top of port 1's so lanes only port 1 enabled survive a collision
    assign wword_1 = merge(mem[address_1], write_data_1, bm_1);
    assign wword_0 = merge((wr_1 && same) ? wword_1 : mem[address_0], write_data_0, bm_0);
    assign rword_0 = merge(mem[address_0], write_data_1, same ? bm_1 : '0);
    assign rword_1 = merge(mem[address_1], write_data_0, same ? bm_0 : '0);

`ifdef SE_SRAM_MRW_2_LANES_INIT_CLEAR_EN
    typedef enum logic {CLEAR, IDLE} clr_state_t;
    clr_state_t                 state;
    logic [address_width-1:0]   clr_addr;
    logic                       clr_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else if (clk__enable && state == CLEAR) begin
            clr_addr <= clr_addr + address_width'(1);
            if (&clr_addr) begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end
    end

    assign clr_we = clk__enable & reset_n & busy;

    always_ff @(posedge clk) begin
        if (wr_1)   mem[address_1] <= wword_1;
        if (wr_0)   mem[address_0] <= wword_0;
        if (clr_we) mem[clr_addr]  <= '0;
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clk) begin
        if (wr_1) mem[address_1] <= wword_1;
        if (wr_0) mem[address_0] <= wword_0;
    end
`endif

    assign init_busy = busy;

    logic [data_width-1:0] rd_data_0_p1, rd_data_1_p1;
    logic                  vld_0_p1, vld_1_p1;

    // Stage p1: array read (with forwarding); data holds until the next read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_0_p1 <= '0;
            rd_data_1_p1 <= '0;
            vld_0_p1     <= 1'b0;
            vld_1_p1     <= 1'b0;
        end else if (clk__enable) begin
            vld_0_p1 <= rd_0;
            vld_1_p1 <= rd_1;
            if (rd_0) rd_data_0_p1 <= rword_0;
            if (rd_1) rd_data_1_p1 <= rword_1;
        end
    end

    if (output_reg) begin : g_out_reg
        // Stage p2: optional output register
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_out_0   <= '0;
                data_out_1   <= '0;
                data_valid_0 <= 1'b0;
                data_valid_1 <= 1'b0;
            end else if (clk__enable) begin
                data_valid_0 <= vld_0_p1;
                data_valid_1 <= vld_1_p1;
                if (vld_0_p1) data_out_0 <= rd_data_0_p1;
                if (vld_1_p1) data_out_1 <= rd_data_1_p1;
            end
        end
    end else begin : g_out_direct
        assign data_out_0   = rd_data_0_p1;
        assign data_out_1   = rd_data_1_p1;
        assign data_valid_0 = vld_0_p1;
        assign data_valid_1 = vld_1_p1;
    end
endmodule

// File: tb/tb_se_sram_mrw_2_lanes.sv
// Directed bench for se_sram_mrw_2_lanes: one instance with read latency 1 (a_*), one with latency 2 (b_*), sharing stimulus.
module tb_se_sram_mrw_2_lanes;
    localparam int AW = 4;
    localparam int DW = 48;
    localparam int NL = 6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clk__enable = 1'b1;
    logic          select_0, select_1, read_not_write_0, read_not_write_1;
    logic [AW-1:0] address_0, address_1;
    logic [DW-1:0] write_data_0, write_data_1;
    logic [NL-1:0] write_lane_enable_0, write_lane_enable_1;
    logic [DW-1:0] a_out_0, a_out_1, b_out_0, b_out_1;
    logic          a_vld_0, a_vld_1, b_vld_0, b_vld_1, a_busy, b_busy;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    se_sram_mrw_2_lanes #(.address_width(AW), .data_width(DW), .lane_width(8), .output_reg(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .clk__enable(clk__enable),
        .select_0(select_0), .select_1(select_1),
        .read_not_write_0(read_not_write_0), .read_not_write_1(read_not_write_1),
        .address_0(address_0), .address_1(address_1),
        .write_data_0(write_data_0), .write_data_1(write_data_1),
        .write_lane_enable_0(write_lane_enable_0), .write_lane_enable_1(write_lane_enable_1),
        .data_out_0(a_out_0), .data_out_1(a_out_1),
        .data_valid_0(a_vld_0), .data_valid_1(a_vld_1), .init_busy(a_busy));

    se_sram_mrw_2_lanes #(.address_width(AW), .data_width(DW), .lane_width(8), .output_reg(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .clk__enable(clk__enable),
        .select_0(select_0), .select_1(select_1),
        .read_not_write_0(read_not_write_0), .read_not_write_1(read_not_write_1),
        .address_0(address_0), .address_1(address_1),
        .write_data_0(write_data_0), .write_data_1(write_data_1),
        .write_lane_enable_0(write_lane_enable_0), .write_lane_enable_1(write_lane_enable_1),
        .data_out_0(b_out_0), .data_out_1(b_out_1),
        .data_valid_0(b_vld_0), .data_valid_1(b_vld_1), .init_busy(b_busy));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic p0(input logic s, input logic rnw, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [NL-1:0] m);
        select_0 = s; read_not_write_0 = rnw; address_0 = a; write_data_0 = d; write_lane_enable_0 = m;
    endtask

    task automatic p1(input logic s, input logic rnw, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [NL-1:0] m);
        select_1 = s; read_not_write_1 = rnw; address_1 = a; write_data_1 = d; write_lane_enable_1 = m;
    endtask

    task automatic idle();
        p0(1'b0, 1'b1, '0, '0, '0);
        p1(1'b0, 1'b1, '0, '0, '0);
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (a_busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        idle();
        reset_n = 1'b0;
        repeat (2) tick();
        check("rst_a_out0", 64'(a_out_0), 64'h0);
        check("rst_a_out1", 64'(a_out_1), 64'h0);
        check("rst_a_vld0", 64'(a_vld_0), 64'h0);
        check("rst_b_out0", 64'(b_out_0), 64'h0);
        check("rst_b_vld1", 64'(b_vld_1), 64'h0);
`ifdef SE_SRAM_MRW_2_LANES_INIT_CLEAR_EN
        check("rst_busy", 64'(a_busy), 64'h1);
        reset_n = 1'b1;
        n = 0;
        while (a_busy && n < 40) begin
            if (n == 5) p0(1'b1, 1'b1, 4'd9, '0, '0);
            else idle();
            tick();
            if (n == 5) check("clr_rd_novld", 64'(a_vld_0), 64'h0);
            n++;
        end
        idle();
        check("clr_len", 64'(n), 64'd16);
        p1(1'b1, 1'b1, 4'd9, '0, '0);
        tick();
        idle();
        check("clr_zero_vld", 64'(a_vld_1), 64'h1);
        check("clr_zero_d", 64'(a_out_1), 64'h0);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        repeat (8) tick();
        check("clr_mid_busy", 64'(a_busy), 64'h1);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        wait_clear(n);
        check("clr_restart_len", 64'(n), 64'd16);
`else
        reset_n = 1'b1;
        tick();
        check("busy_a_zero", 64'(a_busy), 64'h0);
        check("busy_b_zero", 64'(b_busy), 64'h0);
`endif
        // basic write then read on the other port
        idle(); p0(1'b1, 1'b0, 4'd3, 48'h000012345678, 6'h3F); tick();
        idle(); p1(1'b1, 1'b1, 4'd3, '0, '0); tick();
        check("wr_rd_d1", 64'(a_out_1), 64'h000012345678);
        check("wr_rd_v1", 64'(a_vld_1), 64'h1);
        check("wr_no_vld0", 64'(a_vld_0), 64'h0);
        check("wr_no_out0", 64'(a_out_0), 64'h0);
        idle(); tick();
        check("vld1_drop", 64'(a_vld_1), 64'h0);
        check("out1_hold", 64'(a_out_1), 64'h000012345678);
        // lane mask and zero mask
        idle(); p0(1'b1, 1'b0, 4'd3, 48'hFFFFFFFFFFFF, 6'h05); tick();
        idle(); p0(1'b1, 1'b0, 4'd3, 48'h0, 6'h00); tick();
        idle(); p0(1'b1, 1'b1, 4'd3, '0, '0); tick();
        check("mask_rd", 64'(a_out_0), 64'h000012FF56FF);
        // write/write collision
        idle(); p0(1'b1, 1'b0, 4'd7, 48'hAAAAAAAAAAAA, 6'h3F); p1(1'b1, 1'b0, 4'd7, 48'h555555555555, 6'h3F); tick();
        idle(); p0(1'b1, 1'b1, 4'd7, '0, '0); tick();
        check("ww_full", 64'(a_out_0), 64'hAAAAAAAAAAAA);
        idle(); p0(1'b1, 1'b0, 4'd7, 48'hAAAAAAAAAAAA, 6'h0F); p1(1'b1, 1'b0, 4'd7, 48'h555555555555, 6'h30); tick();
        idle(); p0(1'b1, 1'b1, 4'd7, '0, '0); p1(1'b1, 1'b1, 4'd7, '0, '0); tick();
        check("ww_split0", 64'(a_out_0), 64'h5555AAAAAAAA);
        check("ww_split1", 64'(a_out_1), 64'h5555AAAAAAAA);
        // write-through forwarding both directions
        idle(); p1(1'b1, 1'b0, 4'd2, 48'h222222222222, 6'h3F); tick();
        idle(); p0(1'b1, 1'b0, 4'd2, 48'h111111111111, 6'h03); p1(1'b1, 1'b1, 4'd2, '0, '0); tick();
        check("fwd_0to1", 64'(a_out_1), 64'h222222221111);
        idle(); p1(1'b1, 1'b0, 4'd2, 48'h333333333333, 6'h30); p0(1'b1, 1'b1, 4'd2, '0, '0); tick();
        check("fwd_1to0", 64'(a_out_0), 64'h333322221111);
        // clock enable freezes everything, including the array
        idle(); p0(1'b1, 1'b1, 4'd7, '0, '0); tick();
        clk__enable = 1'b0;
        idle(); p0(1'b1, 1'b1, 4'd3, '0, '0); p1(1'b1, 1'b0, 4'd7, 48'h0, 6'h3F); tick();
        check("en_hold_vld", 64'(a_vld_0), 64'h1);
        check("en_hold_d", 64'(a_out_0), 64'h5555AAAAAAAA);
        clk__enable = 1'b1;
        idle(); tick();
        check("en_resume_vld", 64'(a_vld_0), 64'h0);
        idle(); p0(1'b1, 1'b1, 4'd7, '0, '0); tick();
        check("en_no_wr", 64'(a_out_0), 64'h5555AAAAAAAA);
        // output register: latency 2, one result per cycle
        idle(); p0(1'b1, 1'b0, 4'd0, 48'h0A0A0A0A0A0A, 6'h3F); p1(1'b1, 1'b0, 4'd1, 48'h0B0B0B0B0B0B, 6'h3F); tick();
        idle(); repeat (2) tick();
        idle(); p0(1'b1, 1'b1, 4'd0, '0, '0); tick();
        check("or_c1_vld", 64'(b_vld_0), 64'h0);
        idle(); p0(1'b1, 1'b1, 4'd1, '0, '0); tick();
        check("or_c2_vld", 64'(b_vld_0), 64'h1);
        check("or_c2_d", 64'(b_out_0), 64'h0A0A0A0A0A0A);
        idle(); p0(1'b1, 1'b1, 4'd2, '0, '0); tick();
        check("or_c3_vld", 64'(b_vld_0), 64'h1);
        check("or_c3_d", 64'(b_out_0), 64'h0B0B0B0B0B0B);
        idle(); tick();
        check("or_c4_vld", 64'(b_vld_0), 64'h1);
        check("or_c4_d", 64'(b_out_0), 64'h333322221111);
        tick();
        check("or_c5_vld", 64'(b_vld_0), 64'h0);
        check("or_c5_hold", 64'(b_out_0), 64'h333322221111);
        idle(); p0(1'b1, 1'b1, 4'd0, '0, '0); tick();
        idle(); p0(1'b1, 1'b1, 4'd1, '0, '0); tick();
        check("or_en_pre", 64'(b_out_0), 64'h0A0A0A0A0A0A);
        clk__enable = 1'b0;
        idle(); tick();
        check("or_en_hold_vld", 64'(b_vld_0), 64'h1);
        check("or_en_hold_d", 64'(b_out_0), 64'h0A0A0A0A0A0A);
        clk__enable = 1'b1;
        tick();
        check("or_en_resume_vld", 64'(b_vld_0), 64'h1);
        check("or_en_resume_d", 64'(b_out_0), 64'h0B0B0B0B0B0B);
        tick();
        check("or_en_drop", 64'(b_vld_0), 64'h0);
        // reset mid-operation: drop in-flight reads, no write while reset is held
        idle(); p0(1'b1, 1'b0, 4'd5, 48'h5A5A5A5A5A5A, 6'h3F); tick();
        idle(); p0(1'b1, 1'b1, 4'd5, '0, '0); tick();
        reset_n = 1'b0;
        #1;
        check("rst_mid_a_vld", 64'(a_vld_0), 64'h0);
        check("rst_mid_a_out", 64'(a_out_0), 64'h0);
        check("rst_mid_b_vld", 64'(b_vld_0), 64'h0);
        idle(); p0(1'b1, 1'b0, 4'd5, 48'h0, 6'h3F); tick();
        reset_n = 1'b1;
        idle();
        wait_clear(n);
        tick();
        check("rst_b_no_vld", 64'(b_vld_0), 64'h0);
        idle(); p0(1'b1, 1'b1, 4'd5, '0, '0); tick();
        idle();
`ifdef SE_SRAM_MRW_2_LANES_INIT_CLEAR_EN
        check("rst_no_wr", 64'(a_out_0), 64'h0);
`else
        check("rst_no_wr", 64'(a_out_0), 64'h5A5A5A5A5A5A);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
